// File: rtl/sys_arr_ctrl_if.sv
// sys_arr_ctrl_if: bundle between the host/array side and the systolic-array
// sequencer.
//   start, num_vec           host job request (driven by master)
//   busy, done               job status back to the host
//   wbuf_rd, wbuf_addr       weight-buffer read port (1-cycle latency)
//   wwrite                   weight latch strobe shared by all rows
//   dbuf_rd, dbuf_addr       data-buffer read port (1-cycle latency)
//   active[ROWS-1:0]         per-row active, bit r drives row r
//   out_valid, out_addr      bottom-row result capture strobe and vector index
interface sys_arr_ctrl_if #(
  parameter int ROWS    = 2,
  parameter int VEC_W   = 8,
  parameter int WADDR_W = 4
);
  logic               start;
  logic [VEC_W-1:0]   num_vec;
  logic               busy;
  logic               done;
  logic               wbuf_rd;
  logic [WADDR_W-1:0] wbuf_addr;
  logic               wwrite;
  logic               dbuf_rd;
  logic [VEC_W-1:0]   dbuf_addr;
  logic [ROWS-1:0]    active;
  logic               out_valid;
  logic [VEC_W-1:0]   out_addr;

  modport master (
    output start, num_vec,
    input  busy, done, wbuf_rd, wbuf_addr, wwrite, dbuf_rd, dbuf_addr,
           active, out_valid, out_addr
  );

  modport slave (
    input  start, num_vec,
    output busy, done, wbuf_rd, wbuf_addr, wwrite, dbuf_rd, dbuf_addr,
           active, out_valid, out_addr
  );
endinterface

// File: rtl/sys_arr_ctrl.sv
// sys_arr_ctrl: one-job-per-start sequencer for a ROWS x COLS systolic array.
// Preloads weights bottom row first, streams num_vec vectors with per-row
// skew, then tracks results leaving the bottom of the array.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    sys_arr_ctrl_if.slave (host handshake, buffer reads, array controls)
// All outputs come straight from flops.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; latches num_vec on accept
// S_LOAD_W| reading weight rows ROWS-1 down to 0 (one per cycle)
// S_FEED  | reading data vectors 0..N-1 (one per cycle)
// S_DRAIN | waiting for the N-th bottom-row result
// S_DONE  | single cycle, done pulse, then back to idle
module sys_arr_ctrl #(
  parameter int ROWS    = 2,
  parameter int COLS    = 2,
  parameter int VEC_W   = 8,
  parameter int WADDR_W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  sys_arr_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  // Result latency from active[0] to the bottom-row output.
  localparam int LAT = ROWS + COLS;
  localparam logic [WADDR_W-1:0] WADDR_TOP = WADDR_W'(ROWS - 1);

  state_t             state_q, state_d;
  logic [VEC_W-1:0]   n_q, n_d;
  logic [VEC_W-1:0]   n_last;
  logic               wbuf_rd_q, wbuf_rd_d;
  logic [WADDR_W-1:0] wbuf_addr_q, wbuf_addr_d;
  logic               dbuf_rd_q, dbuf_rd_d;
  logic [VEC_W-1:0]   dbuf_addr_q, dbuf_addr_d;
  logic [VEC_W-1:0]   out_addr_q, out_addr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               wwrite_q;
  logic [ROWS-1:0]    active_q;
  logic [LAT-1:0]     vld_q;
  logic               out_valid;

  assign n_last    = n_q - VEC_W'(1);
  assign out_valid = vld_q[LAT-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      wbuf_rd_q   <= 1'b0;
      wbuf_addr_q <= '0;
      dbuf_rd_q   <= 1'b0;
      dbuf_addr_q <= '0;
      out_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wwrite_q    <= 1'b0;
      active_q    <= '0;
      vld_q       <= '0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      wbuf_rd_q   <= wbuf_rd_d;
      wbuf_addr_q <= wbuf_addr_d;
      dbuf_rd_q   <= dbuf_rd_d;
      dbuf_addr_q <= dbuf_addr_d;
      out_addr_q  <= out_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      // Buffer reads have one cycle of latency, so the array controls
      // trail the read enables by one cycle.
      wwrite_q    <= wbuf_rd_q;
      active_q[0] <= dbuf_rd_q;
      for (int r = 1; r < ROWS; r++) begin
        active_q[r] <= active_q[r-1];
      end
      vld_q[0] <= active_q[0];
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    wbuf_rd_d   = 1'b0;
    wbuf_addr_d = wbuf_addr_q;
    dbuf_rd_d   = 1'b0;
    dbuf_addr_d = dbuf_addr_q;
    out_addr_d  = out_valid ? out_addr_q + VEC_W'(1) : out_addr_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          n_d         = bus.num_vec;
          out_addr_d  = '0;
          dbuf_addr_d = '0;
          if (bus.num_vec == '0) begin
            state_d = S_DONE;
          end else begin
            state_d     = S_LOAD_W;
            wbuf_rd_d   = 1'b1;
            wbuf_addr_d = WADDR_TOP;
          end
        end
      end
      S_LOAD_W: begin
        // wbuf_addr doubles as the row down-counter; row 0 is the last read.
        if (wbuf_addr_q == '0) begin
          state_d     = S_FEED;
          dbuf_rd_d   = 1'b1;
          dbuf_addr_d = '0;
        end else begin
          wbuf_rd_d   = 1'b1;
          wbuf_addr_d = wbuf_addr_q - WADDR_W'(1);
        end
      end
      S_FEED: begin
        if (dbuf_addr_q == n_last) begin
          state_d = S_DRAIN;
        end else begin
          dbuf_rd_d   = 1'b1;
          dbuf_addr_d = dbuf_addr_q + VEC_W'(1);
        end
      end
      S_DRAIN: begin
        if (out_valid && (out_addr_q == n_last)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_LOAD_W) || (state_d == S_FEED) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.wbuf_rd   = wbuf_rd_q;
  assign bus.wbuf_addr = wbuf_addr_q;
  assign bus.wwrite    = wwrite_q;
  assign bus.dbuf_rd   = dbuf_rd_q;
  assign bus.dbuf_addr = dbuf_addr_q;
  assign bus.active    = active_q;
  assign bus.out_valid = out_valid;
  assign bus.out_addr  = out_addr_q;

endmodule
